taylor_controller: RTL and testbench
====================================

TAYLOR_CONTROLLER -- requirements
Module: taylor_controller

Interface
REQ-001 SHALL have parameter N_TERMS, default 4, number of series terms summed (legal 2..16).
REQ-002 SHALL have parameter CNT_W, default $clog2(N_TERMS), term-index width (minimum 1).
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  reset; synchronous and active-high.
REQ-005 start  in  1  run request, sampled only in IDLE.
REQ-006 mode  in  1  0 = cos(x), 1 = sin(x); latched into mode_q when start is accepted.
REQ-007 can_continue  in  1  datapath flag; 0 = current term below threshold.
REQ-008 ready  out  1  high only in IDLE.
REQ-009 done  out  1  one-cycle pulse, same cycle as ld_y.
REQ-010 init_ps, init_pp, ld_x, ld_x2, ld_pp, ld_ps, ld_y  out  1 each  datapath register strobes.
REQ-011 pp_sel_x  out  1  pp initial value is x (1) or 1.0 (0).
REQ-012 sel_x2, sel_rom  out  1 each  multiplier operand selects.
REQ-013 sub  out  1  ps update is subtraction when 1.
REQ-014 term_idx  out  CNT_W  current term index k.
REQ-015 rom_addr  out  CNT_W+1  coefficient address {mode_q, term_idx}.

Function
REQ-016 States SHALL be IDLE, INIT, SQ, ACC, CHECK, MUL_X2, MUL_ROM, WRITE; all outputs except sub and rom_addr SHALL be Moore-decoded from state alone.
REQ-017 IDLE: ready=1; start=1 -> INIT, latch mode_q, clear term_idx; otherwise stay.
REQ-018 INIT: init_ps=1, init_pp=1, ld_x=1, pp_sel_x=mode_q -> SQ.
REQ-019 SQ: ld_x2=1 (x*x, sel_x2=0, sel_rom=0) -> ACC.
REQ-020 ACC: ld_ps=1, sub=term_idx[0] -> CHECK.
REQ-021 CHECK: no strobes; term_idx==N_TERMS-1 or can_continue==0 -> WRITE, else -> MUL_X2.
REQ-022 MUL_X2: sel_x2=1, ld_pp=1, term_idx increments by 1 at the end of the cycle -> MUL_ROM.
REQ-023 MUL_ROM: sel_rom=1, ld_pp=1, rom_addr reflects incremented term_idx -> ACC.
REQ-024 WRITE: ld_y=1, done=1 -> IDLE.
REQ-025 term_idx SHALL never exceed N_TERMS-1; no wrap.
REQ-026 Latency: start accepted at edge e0; full run SHALL assert done in cycle 4*N_TERMS+1 after e0 (17 for N_TERMS=4); early stop after term k SHALL assert done in cycle 4*k+5.
REQ-027 start while not IDLE (including WRITE cycle) SHALL be ignored; mode changes after acceptance SHALL have no effect.
REQ-028 start held high SHALL restart after exactly one IDLE cycle following WRITE.
REQ-029 sub and rom_addr outside ACC/MUL_ROM SHALL be 0.

Reset
REQ-030 rst=1 at a clock edge SHALL force IDLE, term_idx=0, mode_q=0, from any state.
REQ-031 Following reset, ready=1 and all other outputs SHALL be 0.
REQ-032 Reset mid-run SHALL abandon the run with no done and no ld_y pulse.

Verification
REQ-033 rst high 2 cycles -> ready=1, every strobe 0, term_idx=0, rom_addr=0.
REQ-034 N_TERMS=4, mode=0, can_continue=1, start 1-cycle pulse -> done in cycle 17; ld_ps pulses 4 times with sub=0,1,0,1; rom_addr in MUL_ROM = 1,2,3.
REQ-035 mode=1, same stimulus -> pp_sel_x=1 in INIT; rom_addr in MUL_ROM = 5,6,7; done in cycle 17.
REQ-036 can_continue=0 from start -> exactly one ld_ps, done in cycle 5, term_idx=0 throughout.
REQ-037 start held high 40 cycles, mode toggled mid-run -> runs of 17 cycles separated by one IDLE cycle; mode_q constant within each run.
REQ-038 rst pulsed during MUL_ROM -> IDLE next cycle, ready=1, no done/ld_y; fresh start then completes normally in 17 cycles.

Source files
------------

// File: rtl/taylor_controller.sv
// Sequencer for a Taylor-series sin/cos datapath: walks the terms, drives register
// strobes and operand selects, and stops early once the datapath reports a negligible term.
module taylor_controller #(
  parameter int N_TERMS = 4,
  parameter int CNT_W   = (N_TERMS > 2) ? $clog2(N_TERMS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic             can_continue,
  output logic             ready,
  output logic             done,
  output logic             init_ps,
  output logic             init_pp,
  output logic             ld_x,
  output logic             ld_x2,
  output logic             ld_pp,
  output logic             ld_ps,
  output logic             ld_y,
  output logic             pp_sel_x,
  output logic             sel_x2,
  output logic             sel_rom,
  output logic             sub,
  output logic [CNT_W-1:0] term_idx,
  output logic [CNT_W:0]   rom_addr
);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    SQ,
    ACC,
    CHECK,
    MUL_X2,
    MUL_ROM,
    WRITE
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_TERMS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] term_idx_q, term_idx_d;
  logic             mode_q, mode_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      term_idx_q <= '0;
      mode_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      term_idx_q <= term_idx_d;
      mode_q     <= mode_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    term_idx_d = term_idx_q;
    mode_d     = mode_q;
    ready      = 1'b0;
    done       = 1'b0;
    init_ps    = 1'b0;
    init_pp    = 1'b0;
    ld_x       = 1'b0;
    ld_x2      = 1'b0;
    ld_pp      = 1'b0;
    ld_ps      = 1'b0;
    ld_y       = 1'b0;
    pp_sel_x   = 1'b0;
    sel_x2     = 1'b0;
    sel_rom    = 1'b0;
    sub        = 1'b0;
    rom_addr   = '0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          state_d    = INIT;
          mode_d     = mode;
          term_idx_d = '0;
        end
      end
      INIT: begin
        init_ps  = 1'b1;
        init_pp  = 1'b1;
        ld_x     = 1'b1;
        pp_sel_x = mode_q;
        state_d  = SQ;
      end
      SQ: begin
        ld_x2   = 1'b1;
        state_d = ACC;
      end
      ACC: begin
        // Series signs alternate, so odd-indexed terms are subtracted.
        ld_ps    = 1'b1;
        sub      = term_idx_q[0];
        rom_addr = {mode_q, term_idx_q};
        state_d  = CHECK;
      end
      CHECK: begin
        if ((term_idx_q == LAST_IDX) || !can_continue) state_d = WRITE;
        else                                            state_d = MUL_X2;
      end
      MUL_X2: begin
        sel_x2 = 1'b1;
        ld_pp  = 1'b1;
        if (term_idx_q != LAST_IDX) term_idx_d = term_idx_q + CNT_W'(1);
        state_d = MUL_ROM;
      end
      MUL_ROM: begin
        sel_rom  = 1'b1;
        ld_pp    = 1'b1;
        rom_addr = {mode_q, term_idx_q};
        state_d  = ACC;
      end
      WRITE: begin
        ld_y    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign term_idx = term_idx_q;

endmodule

// File: tb/tb_taylor_controller.sv
// Randomized self-checking bench for taylor_controller; expectations come from the
// closed-form run timing (done at 4k+5, one ACC per term, alternating signs).
module tb_taylor_controller;
  localparam int N  = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic          can_continue = 1'b1;
  logic          ready, done, init_ps, init_pp, ld_x, ld_x2, ld_pp, ld_ps, ld_y;
  logic          pp_sel_x, sel_x2, sel_rom, sub;
  logic [CW-1:0] term_idx;
  logic [CW:0]   rom_addr;

  int n_cmp  = 0;
  int n_fail = 0;

  int cap_done_cycle, cap_ldps, cap_max_idx, cap_bad, cap_ppsel_init;
  logic cap_ready_after;
  bit sub_q[$];
  int rom_q[$];

  taylor_controller #(.N_TERMS(N), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .can_continue(can_continue),
    .ready(ready), .done(done), .init_ps(init_ps), .init_pp(init_pp), .ld_x(ld_x),
    .ld_x2(ld_x2), .ld_pp(ld_pp), .ld_ps(ld_ps), .ld_y(ld_y), .pp_sel_x(pp_sel_x),
    .sel_x2(sel_x2), .sel_rom(sel_rom), .sub(sub), .term_idx(term_idx), .rom_addr(rom_addr)
  );

  always #5 clk = ~clk;

  // Starts one run and records what the controller does; can_continue drops once
  // term stop_k has been accumulated (stop_k==0 holds it low from the start).
  task automatic run_capture(input logic m, input int stop_k);
    sub_q.delete();
    rom_q.delete();
    cap_done_cycle = -1; cap_ldps = 0; cap_max_idx = 0; cap_bad = 0;
    cap_ppsel_init = -1; cap_ready_after = 1'b0;
    @(negedge clk);
    start = 1'b1; mode = m; can_continue = (stop_k > 0);
    @(posedge clk);
    for (int c = 1; c <= 4 * N + 8; c++) begin
      @(negedge clk);
      if (c == 1) begin start = 1'b0; mode = ~m; end
      if (ready) cap_bad++;
      if (sub && !ld_ps) cap_bad++;
      if ((rom_addr != 0) && !(sel_rom || ld_ps)) cap_bad++;
      if (done !== ld_y) cap_bad++;
      if (int'(term_idx) > cap_max_idx) cap_max_idx = int'(term_idx);
      if (init_ps) cap_ppsel_init = int'(pp_sel_x);
      if (ld_ps) begin sub_q.push_back(sub); cap_ldps++; end
      if (sel_rom) rom_q.push_back(int'(rom_addr));
      can_continue = (stop_k > 0) && (cap_ldps <= stop_k);
      if (done) begin cap_done_cycle = c; break; end
    end
    @(negedge clk);
    cap_ready_after = ready;
  endtask

  task automatic test_reset();
    logic [11:0] strobes;
    rst = 1'b1; start = 1'b0; mode = 1'b0; can_continue = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    strobes = {done, init_ps, init_pp, ld_x, ld_x2, ld_pp, ld_ps, ld_y, pp_sel_x, sel_x2, sel_rom, sub};
    n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready: got %b expected 1", ready); end
    n_cmp++; if (strobes !== 12'h000) begin n_fail++; $display("[TB] FAIL reset_strobes: got %h expected 000", strobes); end
    n_cmp++; if (term_idx !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_term_idx: got %0d expected 0", term_idx); end
    n_cmp++; if (rom_addr !== 3'd0) begin n_fail++; $display("[TB] FAIL reset_rom_addr: got %0d expected 0", rom_addr); end
    rst = 1'b0;
  endtask

  task automatic test_full_run(input logic m);
    run_capture(m, N);
    n_cmp++; if (cap_done_cycle != 4 * N + 1) begin n_fail++; $display("[TB] FAIL full_done_cycle m=%0d: got %0d expected %0d", m, cap_done_cycle, 4 * N + 1); end
    n_cmp++; if (cap_ldps != N) begin n_fail++; $display("[TB] FAIL full_ldps_count m=%0d: got %0d expected %0d", m, cap_ldps, N); end
    for (int i = 0; i < N && i < sub_q.size(); i++) begin
      n_cmp++; if (int'(sub_q[i]) != i % 2) begin n_fail++; $display("[TB] FAIL full_sub[%0d] m=%0d: got %0d expected %0d", i, m, sub_q[i], i % 2); end
    end
    n_cmp++; if (rom_q.size() != N - 1) begin n_fail++; $display("[TB] FAIL full_rom_count m=%0d: got %0d expected %0d", m, rom_q.size(), N - 1); end
    for (int k = 1; k < N && k <= rom_q.size(); k++) begin
      n_cmp++; if (rom_q[k-1] != int'(m) * (1 << CW) + k) begin n_fail++; $display("[TB] FAIL full_rom_addr[%0d] m=%0d: got %0d expected %0d", k, m, rom_q[k-1], int'(m) * (1 << CW) + k); end
    end
    n_cmp++; if (cap_ppsel_init != int'(m)) begin n_fail++; $display("[TB] FAIL full_pp_sel_x m=%0d: got %0d expected %0d", m, cap_ppsel_init, m); end
    n_cmp++; if (cap_bad != 0) begin n_fail++; $display("[TB] FAIL full_stray_outputs m=%0d: got %0d expected 0", m, cap_bad); end
    n_cmp++; if (cap_ready_after !== 1'b1) begin n_fail++; $display("[TB] FAIL full_ready_after m=%0d: got %b expected 1", m, cap_ready_after); end
  endtask

  task automatic test_early_stop();
    run_capture(1'b0, 0);
    n_cmp++; if (cap_done_cycle != 5) begin n_fail++; $display("[TB] FAIL early_done_cycle: got %0d expected 5", cap_done_cycle); end
    n_cmp++; if (cap_ldps != 1) begin n_fail++; $display("[TB] FAIL early_ldps_count: got %0d expected 1", cap_ldps); end
    n_cmp++; if (cap_max_idx != 0) begin n_fail++; $display("[TB] FAIL early_term_idx: got %0d expected 0", cap_max_idx); end
    n_cmp++; if (cap_bad != 0) begin n_fail++; $display("[TB] FAIL early_stray_outputs: got %0d expected 0", cap_bad); end
  endtask

  task automatic test_random_runs();
    for (int r = 0; r < 8; r++) begin
      logic m;
      int   stop, exp_k;
      m     = 1'($urandom % 2);
      stop  = $urandom_range(0, N);
      exp_k = (stop > N - 1) ? N - 1 : stop;
      run_capture(m, stop);
      n_cmp++; if (cap_done_cycle != 4 * exp_k + 5) begin n_fail++; $display("[TB] FAIL rand_done_cycle r=%0d: got %0d expected %0d", r, cap_done_cycle, 4 * exp_k + 5); end
      n_cmp++; if (cap_ldps != exp_k + 1) begin n_fail++; $display("[TB] FAIL rand_ldps_count r=%0d: got %0d expected %0d", r, cap_ldps, exp_k + 1); end
      n_cmp++; if (cap_max_idx != exp_k) begin n_fail++; $display("[TB] FAIL rand_max_term_idx r=%0d: got %0d expected %0d", r, cap_max_idx, exp_k); end
      for (int i = 0; i < sub_q.size(); i++) begin
        n_cmp++; if (int'(sub_q[i]) != i % 2) begin n_fail++; $display("[TB] FAIL rand_sub[%0d] r=%0d: got %0d expected %0d", i, r, sub_q[i], i % 2); end
      end
      for (int k = 1; k <= rom_q.size(); k++) begin
        n_cmp++; if (rom_q[k-1] != int'(m) * (1 << CW) + k) begin n_fail++; $display("[TB] FAIL rand_rom_addr[%0d] r=%0d: got %0d expected %0d", k, r, rom_q[k-1], int'(m) * (1 << CW) + k); end
      end
      n_cmp++; if (cap_bad != 0) begin n_fail++; $display("[TB] FAIL rand_stray_outputs r=%0d: got %0d expected 0", r, cap_bad); end
    end
  endtask

  // Runs are 17 cycles plus one IDLE cycle, so run r is accepted at edge 18*r.
  task automatic test_back_to_back();
    logic done_at[1:60], ready_at[1:60], init_at[1:60], ppsel_at[1:60];
    int   rom_hi_at[1:60];
    logic mode_sent[0:60];
    can_continue = 1'b1;
    @(negedge clk);
    start = 1'b1; mode = 1'($urandom % 2); mode_sent[0] = mode;
    @(posedge clk);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      done_at[c]   = done;
      ready_at[c]  = ready;
      init_at[c]   = init_ps;
      ppsel_at[c]  = pp_sel_x;
      rom_hi_at[c] = sel_rom ? int'(rom_addr[CW]) : -1;
      if (c == 40) start = 1'b0;
      if (c % 5 == 0) mode = ~mode;
      mode_sent[c] = mode;
    end
    for (int c = 1; c <= 60; c++) begin
      logic exp_done, exp_ready;
      exp_done  = (c % 18 == 17) && (c <= 53);
      exp_ready = (c % 18 == 0) || (c >= 54);
      n_cmp++; if (done_at[c] !== exp_done) begin n_fail++; $display("[TB] FAIL b2b_done cycle %0d: got %b expected %b", c, done_at[c], exp_done); end
      n_cmp++; if (ready_at[c] !== exp_ready) begin n_fail++; $display("[TB] FAIL b2b_ready cycle %0d: got %b expected %b", c, ready_at[c], exp_ready); end
      if (rom_hi_at[c] >= 0) begin
        n_cmp++; if (rom_hi_at[c] != int'(mode_sent[18 * ((c - 1) / 18)])) begin n_fail++; $display("[TB] FAIL b2b_mode cycle %0d: got %0d expected %0d", c, rom_hi_at[c], mode_sent[18 * ((c - 1) / 18)]); end
      end
      if ((c % 18 == 1) && (c <= 37)) begin
        n_cmp++; if ({init_at[c], ppsel_at[c]} !== {1'b1, mode_sent[c-1]}) begin n_fail++; $display("[TB] FAIL b2b_init cycle %0d: got %b%b expected 1%b", c, init_at[c], ppsel_at[c], mode_sent[c-1]); end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int found, stray;
    found = 0; stray = 0;
    @(negedge clk);
    start = 1'b1; mode = 1'b1; can_continue = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (sel_rom) begin found = c; break; end
    end
    n_cmp++; if (found != 6) begin n_fail++; $display("[TB] FAIL midrst_first_mul_rom: got %0d expected 6", found); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_ready: got %b expected 1", ready); end
    n_cmp++; if ({done, ld_y} !== 2'b00) begin n_fail++; $display("[TB] FAIL midrst_done_ldy: got %b%b expected 00", done, ld_y); end
    n_cmp++; if ({term_idx, rom_addr} !== 5'd0) begin n_fail++; $display("[TB] FAIL midrst_idx_addr: got %0d/%0d expected 0/0", term_idx, rom_addr); end
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (done || ld_y || !ready) stray++;
    end
    n_cmp++; if (stray != 0) begin n_fail++; $display("[TB] FAIL midrst_abandoned: got %0d stray cycles expected 0", stray); end
    run_capture(1'b0, N);
    n_cmp++; if (cap_done_cycle != 4 * N + 1) begin n_fail++; $display("[TB] FAIL midrst_rerun_done: got %0d expected %0d", cap_done_cycle, 4 * N + 1); end
    n_cmp++; if (rom_q.size() != N - 1 || rom_q[0] != 1) begin n_fail++; $display("[TB] FAIL midrst_rerun_rom: got %0d entries expected %0d starting at 1", rom_q.size(), N - 1); end
  endtask

  initial begin
    test_reset();
    test_full_run(1'b0);
    test_full_run(1'b1);
    test_early_stop();
    test_random_runs();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
